// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, drives the IM req/ack handshake and
// arbitrates redirects, stall, halt and IM timeout; mirrors PC updates out.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  input  logic        uncond_br,
  input  logic [31:0] uncond_target,
  input  logic        cond_br_taken,
  input  logic [31:0] cond_target,
  input  logic        stall,
  input  logic        halt,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic        pc_wr,
  output logic [31:0] pc_wr_val,
  output logic        flush,
  output logic        fetch_err
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_STALLED,
    S_HALTED
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [7:0]  wait_cnt_q;
  logic        redirect_pend_q;
  logic        pend_cond_q;
  logic [31:0] pend_target_q;
  logic        halt_pend_q;

  logic        im_req_q;
  logic [31:0] instr_out_q;
  logic        instr_valid_q;
  logic        pc_wr_q;
  logic [31:0] pc_wr_val_q;
  logic        flush_q;
  logic        fetch_err_q;

  logic        new_redir;
  logic        take_new;
  logic        redir_any;
  logic        redir_cond;
  logic [31:0] redir_target;
  logic        halt_any;
  logic        wait_max;
  logic [31:0] pc_inc;

  // Pending redirect/halt are only ever set in WAIT and cleared on leaving it,
  // so the merged view below is also correct in REQ and STALLED.
  always_comb begin
    new_redir    = cond_br_taken | uncond_br;
    take_new     = cond_br_taken | (uncond_br & ~(redirect_pend_q & pend_cond_q));
    redir_any    = redirect_pend_q | new_redir;
    redir_cond   = take_new ? cond_br_taken : pend_cond_q;
    redir_target = (take_new ? (cond_br_taken ? cond_target : uncond_target)
                             : pend_target_q) & ~32'h3;
    halt_any     = halt_pend_q | halt;
    wait_max     = (wait_cnt_q == MAX_WAIT_C);
    pc_inc       = pc_q + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= S_BOOT;
      pc_q            <= RESET_PC;
      wait_cnt_q      <= 8'd0;
      redirect_pend_q <= 1'b0;
      pend_cond_q     <= 1'b0;
      pend_target_q   <= 32'd0;
      halt_pend_q     <= 1'b0;
      im_req_q        <= 1'b0;
      instr_out_q     <= 32'd0;
      instr_valid_q   <= 1'b0;
      pc_wr_q         <= 1'b0;
      pc_wr_val_q     <= RESET_PC;
      flush_q         <= 1'b0;
      fetch_err_q     <= 1'b0;
    end else begin
      pc_wr_q <= 1'b0;
      flush_q <= 1'b0;
      case (state_q)
        S_BOOT: begin
          pc_wr_q     <= 1'b1;
          pc_wr_val_q <= pc_q;
          im_req_q    <= 1'b1;
          state_q     <= S_REQ;
        end

        S_REQ, S_WAIT, S_STALLED: begin
          if (state_q == S_WAIT && !im_ack) begin
            // Access in flight cannot be cancelled: time it out or queue events.
            if (wait_max) begin
              fetch_err_q     <= 1'b1;
              im_req_q        <= 1'b0;
              instr_valid_q   <= 1'b0;
              redirect_pend_q <= 1'b0;
              halt_pend_q     <= 1'b0;
              wait_cnt_q      <= 8'd0;
              state_q         <= S_HALTED;
            end else begin
              wait_cnt_q <= wait_cnt_q + 8'd1;
              if (new_redir) begin
                redirect_pend_q <= 1'b1;
                pend_cond_q     <= redir_cond;
                pend_target_q   <= redir_target;
              end
              if (halt) begin
                halt_pend_q <= 1'b1;
              end
              if (!stall) begin
                instr_valid_q <= 1'b0;
              end
            end
          end else if (redir_any) begin
            // Any word returned this cycle is dropped; redirect overrides stall.
            pc_q            <= redir_target;
            pc_wr_q         <= 1'b1;
            pc_wr_val_q     <= redir_target;
            flush_q         <= 1'b1;
            instr_valid_q   <= 1'b0;
            redirect_pend_q <= 1'b0;
            halt_pend_q     <= 1'b0;
            wait_cnt_q      <= 8'd0;
            im_req_q        <= ~halt_any;
            state_q         <= halt_any ? S_HALTED : S_REQ;
          end else if (halt_any) begin
            im_req_q      <= 1'b0;
            instr_valid_q <= 1'b0;
            halt_pend_q   <= 1'b0;
            wait_cnt_q    <= 8'd0;
            state_q       <= S_HALTED;
          end else if (state_q == S_STALLED) begin
            if (!stall) begin
              im_req_q      <= 1'b1;
              instr_valid_q <= 1'b0;
              state_q       <= S_REQ;
            end
          end else if (im_ack) begin
            wait_cnt_q <= 8'd0;
            if (stall) begin
              // Word dropped and refetched once the stall lifts.
              im_req_q <= 1'b0;
              state_q  <= S_STALLED;
            end else begin
              instr_out_q   <= im_rdata;
              instr_valid_q <= 1'b1;
              pc_q          <= pc_inc;
              pc_wr_q       <= 1'b1;
              pc_wr_val_q   <= pc_inc;
              im_req_q      <= 1'b1;
              state_q       <= S_REQ;
            end
          end else begin
            wait_cnt_q <= 8'd1;
            state_q    <= S_WAIT;
            if (!stall) begin
              instr_valid_q <= 1'b0;
            end
          end
        end

        S_HALTED: begin
          im_req_q      <= 1'b0;
          instr_valid_q <= 1'b0;
        end

        default: begin
          state_q <= S_BOOT;
        end
      endcase
    end
  end

  assign im_req      = im_req_q;
  assign im_addr     = pc_q;
  assign instr_out   = instr_out_q;
  assign instr_valid = instr_valid_q;
  assign pc_wr       = pc_wr_q;
  assign pc_wr_val   = pc_wr_val_q;
  assign flush       = flush_q;
  assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios then random traffic,
// all compared cycle by cycle against an event-level reference model.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int          MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic        uncond_br;
  logic [31:0] uncond_target;
  logic        cond_br_taken;
  logic [31:0] cond_target;
  logic        stall;
  logic        halt;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        pc_wr;
  logic [31:0] pc_wr_val;
  logic        flush;
  logic        fetch_err;

  always #5 clk = ~clk;

  // Instruction memory content: word at address A reads as 0xA0 + A.
  assign im_rdata = 32'hA0 + im_addr;

  fetch_ctrl #(.RESET_PC(RESET_PC), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack), .im_rdata(im_rdata),
    .uncond_br(uncond_br), .uncond_target(uncond_target),
    .cond_br_taken(cond_br_taken), .cond_target(cond_target),
    .stall(stall), .halt(halt),
    .instr_out(instr_out), .instr_valid(instr_valid),
    .pc_wr(pc_wr), .pc_wr_val(pc_wr_val), .flush(flush), .fetch_err(fetch_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: tracks the fetch as events (boot, in-flight access with
  // age, queued redirect with priority, latched halt) rather than FSM states.
  bit          m_boot, m_halted, m_stalled, m_active, m_halt_req;
  int          m_age, m_pend_prio;
  logic [31:0] m_pend_tgt, m_pc;
  logic        e_valid, e_pcwr, e_flush, e_err;
  logic [31:0] e_instr, e_pcwr_val;

  function automatic void go_halt();
    m_halted = 1'b1;
    m_active = 1'b0;
    e_valid  = 1'b0;
  endfunction

  function automatic void model_step();
    int prio;
    if (!reset) begin
      m_boot = 1; m_halted = 0; m_stalled = 0; m_active = 0; m_halt_req = 0;
      m_age = 0; m_pend_prio = 0; m_pend_tgt = 0; m_pc = RESET_PC;
      e_valid = 0; e_instr = 0; e_pcwr = 0; e_pcwr_val = RESET_PC; e_flush = 0; e_err = 0;
      return;
    end
    e_pcwr  = 0;
    e_flush = 0;
    if (m_boot) begin
      m_boot = 0; m_active = 1; m_age = 0;
      e_pcwr = 1; e_pcwr_val = m_pc;
      return;
    end
    if (m_halted) begin
      e_valid = 0;
      return;
    end
    prio = cond_br_taken ? 2 : (uncond_br ? 1 : 0);
    if (prio != 0 && prio >= m_pend_prio) begin
      m_pend_prio = prio;
      m_pend_tgt  = (cond_br_taken ? cond_target : uncond_target) & ~32'h3;
    end
    if (halt) m_halt_req = 1;
    if (m_active && m_age > 0 && !im_ack) begin
      if (m_age == MAX_WAIT) begin
        e_err = 1;
        go_halt();
      end else begin
        m_age++;
        if (!stall) e_valid = 0;
      end
      return;
    end
    if (m_pend_prio != 0) begin
      m_pc = m_pend_tgt; e_pcwr = 1; e_pcwr_val = m_pc; e_flush = 1; e_valid = 0;
      m_pend_prio = 0; m_stalled = 0;
      if (m_halt_req) go_halt();
      else begin m_active = 1; m_age = 0; end
      return;
    end
    if (m_halt_req) begin
      go_halt();
      return;
    end
    if (m_stalled) begin
      if (!stall) begin m_stalled = 0; m_active = 1; m_age = 0; e_valid = 0; end
      return;
    end
    if (im_ack) begin
      if (stall) begin
        m_stalled = 1; m_active = 0;
      end else begin
        e_instr = 32'hA0 + m_pc; e_valid = 1;
        m_pc = m_pc + 32'd4; e_pcwr = 1; e_pcwr_val = m_pc; m_age = 0;
      end
    end else begin
      m_age = 1;
      if (!stall) e_valid = 0;
    end
  endfunction

  task automatic cycle(input bit rst_n, input bit ack, input bit ub, input logic [31:0] ut,
                       input bit cb, input logic [31:0] ct, input bit st, input bit hl);
    reset = rst_n; im_ack = ack; uncond_br = ub; uncond_target = ut;
    cond_br_taken = cb; cond_target = ct; stall = st; halt = hl;
    @(posedge clk);
    model_step();
    #1;
    check_eq("im_req",      32'(im_req),      32'(m_active));
    check_eq("im_addr",     im_addr,          m_pc);
    check_eq("instr_valid", 32'(instr_valid), 32'(e_valid));
    check_eq("instr_out",   instr_out,        e_instr);
    check_eq("pc_wr",       32'(pc_wr),       32'(e_pcwr));
    check_eq("pc_wr_val",   pc_wr_val,        e_pcwr_val);
    check_eq("flush",       32'(flush),       32'(e_flush));
    check_eq("fetch_err",   32'(fetch_err),   32'(e_err));
    $display("cyc t=%0t rst=%0b ack=%0b ub=%0b cb=%0b st=%0b hl=%0b | req=%0b addr=%h v=%0b instr=%h pcwr=%0b val=%h fl=%0b err=%0b",
             $time, rst_n, ack, ub, cb, st, hl, im_req, im_addr, instr_valid, instr_out,
             pc_wr, pc_wr_val, flush, fetch_err);
  endtask

  task automatic idle(input bit ack, input int n);
    for (int i = 0; i < n; i++) cycle(1, ack, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic redirect(input bit ack, input logic [31:0] tgt, input bit st);
    cycle(1, ack, 1, tgt, 0, 0, st, 0);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int ack_pct;
    bit r_rst, r_ack, r_ub, r_cb, r_st, r_hl;
    logic [31:0] r_ut, r_ct;

    reset = 0; im_ack = 0; uncond_br = 0; uncond_target = 0;
    cond_br_taken = 0; cond_target = 0; stall = 0; halt = 0;

    do_reset();
    idle(1, 6);                                  // boot + zero-wait stream
    idle(0, 3); idle(1, 2);                      // 3 wait states then ack
    idle(0, 12);                                 // timeout -> fetch_err, halted
    do_reset(); idle(1, 4);
    cycle(1, 1, 1, 32'h200, 1, 32'h303, 0, 0);   // cond beats uncond, masked
    idle(1, 2);
    idle(0, 1); redirect(0, 32'h400, 0); idle(0, 1); idle(1, 3);
    cycle(1, 1, 0, 0, 0, 0, 1, 0); cycle(1, 1, 0, 0, 0, 0, 1, 0);
    cycle(1, 1, 0, 0, 0, 0, 1, 0); cycle(1, 1, 0, 0, 0, 0, 1, 0);
    redirect(1, 32'h80, 1); idle(1, 3);
    redirect(0, 32'hFFFF_FFFC, 0); idle(1, 3);   // PC wrap to 0
    redirect(0, 32'h10, 0); idle(0, 3);          // into WAIT at 0x10
    cycle(0, 1, 0, 0, 0, 0, 0, 0);               // reset mid-WAIT, late ack
    idle(1, 4);
    cycle(1, 1, 1, 32'h600, 0, 0, 0, 1);         // redirect + halt together
    idle(1, 3);
    do_reset(); idle(1, 2);
    idle(0, 1); cycle(1, 0, 0, 0, 0, 0, 0, 1); idle(0, 2); idle(1, 2); // halt in WAIT

    ack_pct = 100;
    for (int c = 0; c < 3000; c++) begin
      if (c % 40 == 0) begin
        case ($urandom_range(0, 3))
          0: ack_pct = 100;
          1: ack_pct = 70;
          2: ack_pct = 30;
          default: ack_pct = 0;
        endcase
      end
      r_rst = !((c % 170 == 0) || ($urandom_range(0, 299) == 0));
      r_ack = ($urandom_range(1, 100) <= ack_pct);
      r_ub  = ($urandom_range(0, 9) == 0);
      r_cb  = ($urandom_range(0, 11) == 0);
      r_ut  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                          : (32'($urandom) & 32'h0000_0FFF);
      r_ct  = 32'($urandom) & 32'h0000_FFFF;
      r_st  = ($urandom_range(0, 5) == 0);
      r_hl  = ($urandom_range(0, 79) == 0);
      cycle(r_rst, r_ack, r_ub, r_ut, r_cb, r_ct, r_st, r_hl);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
